msrh_rob_flush_ctrl: RTL and testbench
======================================

Name: msrh_rob_flush_ctrl

Overview:
Sequences ROB allocation and pipeline recovery around the commit block. Tracks ROB occupancy to generate the dispatch stall, and on a flushing commit (branch mispredict or exception) runs a fixed sequence: broadcast flush, drain dead ROB entries, redirect the frontend. Sits between the ROB commit output, the dispatch stage and the frontend PC-redirect port.

Parameters:
CMT_BLK_SIZE, 16, number of ROB commit blocks (power of 2, >=2)
VADDR_W, 39, virtual address width
EXCEPT_W, 5, exception-type encoding width

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous active-low reset
i_disp_valid  in  1  dispatch group request (one ROB block)
o_disp_stall  out  1  dispatch must not allocate this cycle
i_cmt_commit  in  1  ROB commits one block this cycle
i_cmt_flush_valid  in  1  committed block carries PC update
i_cmt_all_dead  in  1  committed block is a killed (dead) block
i_cmt_except_valid  in  1  committed block raised an exception
i_cmt_except_type  in  EXCEPT_W  exception cause
i_cmt_upd_pc_vaddr  in  VADDR_W  branch target of committed block
i_trap_vec  in  VADDR_W  trap handler address
o_flush_valid  out  1  one-cycle pipeline flush broadcast
o_trap_valid  out  1  one-cycle trap report, same cycle as o_flush_valid
o_trap_cause  out  EXCEPT_W  captured cause, valid with o_trap_valid
o_redirect_valid  out  1  frontend redirect request
o_redirect_vaddr  out  VADDR_W  redirect target
i_redirect_ready  in  1  frontend accepts redirect
o_occupancy  out  $clog2(CMT_BLK_SIZE)+1  allocated ROB blocks

Behaviour:
- Reset (synchronous, i_reset_n==0 at posedge): state IDLE, occupancy 0, captured target/cause 0. All outputs 0, except o_disp_stall, which is 0 (IDLE, empty). Reset mid-sequence aborts to IDLE immediately.
- Accepted dispatch: alloc = i_disp_valid & !o_disp_stall. i_disp_valid while stalled is ignored and has no count effect.
- Dealloc = i_cmt_commit. Occupancy next = occ + alloc - dealloc. Simultaneous alloc and dealloc leave it unchanged. Dealloc at occ==0 is a protocol error (SIMULATION assertion); the count saturates at 0.
- o_disp_stall = (state != IDLE) | (occ == CMT_BLK_SIZE). This is purely registered-state based; same-cycle commit does not release a full stall.
- Flush trigger: trig = i_cmt_commit & i_cmt_flush_valid & !i_cmt_all_dead.
- On trig, capture target = i_cmt_except_valid ? i_trap_vec : i_cmt_upd_pc_vaddr. Capture cause and an except flag.
- State IDLE: trig -> FLUSH.
- State FLUSH (exactly 1 cycle): o_flush_valid=1. o_trap_valid = captured except flag. Always -> DRAIN.
- State DRAIN: waits while the ROB retires dead blocks (commits with all_dead). Transitions to REDIRECT when registered occ==0. A further trig during DRAIN is ignored (a non-dead block there is a protocol error and is asserted); its commit still decrements.
- State REDIRECT: o_redirect_valid=1, o_redirect_vaddr = captured target, both held stable until i_redirect_ready. On ready -> IDLE. Dispatch resumes the next cycle.
- Timing: trig at cycle N gives o_flush_valid at N+1 and DRAIN at N+2. The earliest redirect is N+3 if occ reached 0. Redirect done at ready cycle R; dispatch is allowed at R+1.
- A trig with a non-dead commit at IDLE decrements the count in the same cycle as the capture.

Decomposition:
- msrh_pkg: flush_ctrl_state_t enum {IDLE, FLUSH, DRAIN, REDIRECT}. Reuse except_t width for EXCEPT_W where available.
- One sub-module: msrh_rob_occ_cnt (up/down saturating counter with full/empty flags, parameter SIZE).

Test Plan:
- Fill: 16 dispatches, no commits -> occ=16, o_disp_stall=1. Then simultaneous disp+commit -> occ stays 16, dispatch is not accepted, occ=15 next cycle.
- Branch flush: occ=5, commit with flush_valid, target 0x8000_1000 -> occ=4, o_flush_valid pulse at N+1. Four all_dead commits follow. Then o_redirect_valid=1 with vaddr 0x8000_1000, held through 3 cycles of ready=0, and IDLE after ready.
- Exception: occ=1, commit with except_valid, cause 2, i_trap_vec=0x100 -> o_trap_valid=1 with cause 2 at N+1. Redirect to 0x100 at N+3.
- Stall during recovery: i_disp_valid held high through FLUSH/DRAIN/REDIRECT -> occ never increments; the first allocation is the cycle after ready.
- Reset mid-DRAIN: i_reset_n=0 for one cycle at occ=3 -> next cycle state IDLE, occ=0, all outputs 0.
- Second flush-valid commit during DRAIN (all_dead=1) -> no new capture; the target stays at the first value.

Source files
------------

// File: rtl/msrh_pkg.sv
// Shared types for the ROB flush controller: the recovery FSM encoding and the
// exception-cause width.
package msrh_pkg;

    localparam int EXCEPT_W_DEF = 5;

    typedef logic [EXCEPT_W_DEF-1:0] except_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        DRAIN    = 2'd2,
        REDIRECT = 2'd3
    } flush_ctrl_state_t;

endpackage

// File: rtl/msrh_rob_occ_cnt.sv
// ROB block occupancy counter: one allocation and one retirement per cycle,
// holding at zero if a retirement arrives with nothing allocated.
module msrh_rob_occ_cnt #(
    parameter int SIZE = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_inc,
    input  logic                   i_dec,
    output logic [$clog2(SIZE):0]  o_cnt,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int W = $clog2(SIZE) + 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_inc && !i_dec) begin
            cnt_d = cnt_q + W'(1);
        end else if (i_dec && !i_inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_reset_n) begin
            assert (!(i_dec && !i_inc && (cnt_q == '0)))
                else $error("occ_cnt: retirement with ROB empty");
        end
    end
`endif

    assign o_cnt   = cnt_q;
    assign o_full  = (cnt_q == W'(SIZE));
    assign o_empty = (cnt_q == '0);

endmodule

// File: rtl/msrh_rob_flush_ctrl.sv
// ROB allocation stall and flush recovery sequencer: FLUSH broadcast, drain of
// dead blocks until the ROB is empty, then a held frontend redirect.
module msrh_rob_flush_ctrl
    import msrh_pkg::*;
#(
    parameter int CMT_BLK_SIZE = 16,
    parameter int VADDR_W      = 39,
    parameter int EXCEPT_W     = EXCEPT_W_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_disp_valid,
    output logic                          o_disp_stall,
    input  logic                          i_cmt_commit,
    input  logic                          i_cmt_flush_valid,
    input  logic                          i_cmt_all_dead,
    input  logic                          i_cmt_except_valid,
    input  logic [EXCEPT_W-1:0]           i_cmt_except_type,
    input  logic [VADDR_W-1:0]            i_cmt_upd_pc_vaddr,
    input  logic [VADDR_W-1:0]            i_trap_vec,
    output logic                          o_flush_valid,
    output logic                          o_trap_valid,
    output logic [EXCEPT_W-1:0]           o_trap_cause,
    output logic                          o_redirect_valid,
    output logic [VADDR_W-1:0]            o_redirect_vaddr,
    input  logic                          i_redirect_ready,
    output logic [$clog2(CMT_BLK_SIZE):0] o_occupancy
);

    flush_ctrl_state_t    state_q, state_d;
    logic [VADDR_W-1:0]   target_q, target_d;
    logic [EXCEPT_W-1:0]  cause_q, cause_d;
    logic                 except_q, except_d;

    logic occ_full, occ_empty;
    logic alloc, trig;

    // Stall depends only on registered state so dispatch never sees a
    // combinational path from the commit port.
    assign o_disp_stall = (state_q != IDLE) | occ_full;
    assign alloc        = i_disp_valid & ~o_disp_stall;
    assign trig         = i_cmt_commit & i_cmt_flush_valid & ~i_cmt_all_dead;

    msrh_rob_occ_cnt #(
        .SIZE (CMT_BLK_SIZE)
    ) u_occ (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (alloc),
        .i_dec     (i_cmt_commit),
        .o_cnt     (o_occupancy),
        .o_full    (occ_full),
        .o_empty   (occ_empty)
    );

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cause_d  = cause_q;
        except_d = except_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d  = FLUSH;
                    target_d = i_cmt_except_valid ? i_trap_vec : i_cmt_upd_pc_vaddr;
                    cause_d  = i_cmt_except_type;
                    except_d = i_cmt_except_valid;
                end
            end
            FLUSH:    state_d = DRAIN;
            DRAIN:    if (occ_empty) state_d = REDIRECT;
            REDIRECT: if (i_redirect_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            cause_q  <= '0;
            except_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cause_q  <= cause_d;
            except_q <= except_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_reset_n && (state_q == DRAIN)) begin
            assert (!trig)
                else $error("flush_ctrl: live flushing commit while draining");
        end
    end
`endif

    // Payloads are zeroed outside their valid cycle so idle outputs read 0.
    assign o_flush_valid    = (state_q == FLUSH);
    assign o_trap_valid     = o_flush_valid & except_q;
    assign o_trap_cause     = o_trap_valid ? cause_q : '0;
    assign o_redirect_valid = (state_q == REDIRECT);
    assign o_redirect_vaddr = o_redirect_valid ? target_q : '0;

endmodule

// File: tb/tb_msrh_rob_flush_ctrl.sv
// Directed vector bench for msrh_rob_flush_ctrl: a stimulus/expectation table
// plus short hand sequences for fill, recovery stall and mid-drain reset.
module tb_msrh_rob_flush_ctrl;

    localparam int SZ = 16;
    localparam int VW = 39;
    localparam int EW = 5;
    localparam int OW = $clog2(SZ) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          disp_valid, disp_stall;
    logic          cmt_commit, cmt_flush_valid, cmt_all_dead, cmt_except_valid;
    logic [EW-1:0] cmt_except_type;
    logic [VW-1:0] cmt_upd_pc, trap_vec;
    logic          flush_valid, trap_valid, redirect_valid, redirect_ready;
    logic [EW-1:0] trap_cause;
    logic [VW-1:0] redirect_vaddr;
    logic [OW-1:0] occupancy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    msrh_rob_flush_ctrl #(
        .CMT_BLK_SIZE (SZ),
        .VADDR_W      (VW),
        .EXCEPT_W     (EW)
    ) dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_disp_valid       (disp_valid),
        .o_disp_stall       (disp_stall),
        .i_cmt_commit       (cmt_commit),
        .i_cmt_flush_valid  (cmt_flush_valid),
        .i_cmt_all_dead     (cmt_all_dead),
        .i_cmt_except_valid (cmt_except_valid),
        .i_cmt_except_type  (cmt_except_type),
        .i_cmt_upd_pc_vaddr (cmt_upd_pc),
        .i_trap_vec         (trap_vec),
        .o_flush_valid      (flush_valid),
        .o_trap_valid       (trap_valid),
        .o_trap_cause       (trap_cause),
        .o_redirect_valid   (redirect_valid),
        .o_redirect_vaddr   (redirect_vaddr),
        .i_redirect_ready   (redirect_ready),
        .o_occupancy        (occupancy)
    );

    typedef struct {
        logic          rst, disp, cmt, fv, dead, exc;
        logic [EW-1:0] cause;
        logic [VW-1:0] pc, tv;
        logic          rdy;
        logic          e_stall, e_flush, e_trap;
        logic [EW-1:0] e_cause;
        logic          e_rv;
        logic [VW-1:0] e_raddr;
        logic [OW-1:0] e_occ;
    } vec_t;

    function automatic vec_t mk(
        logic rst, logic disp, logic cmt, logic fv, logic dead, logic exc,
        logic [EW-1:0] cause, logic [VW-1:0] pc, logic [VW-1:0] tv, logic rdy,
        logic es, logic ef, logic et, logic [EW-1:0] ec, logic erv,
        logic [VW-1:0] era, logic [OW-1:0] eo);
        vec_t r;
        r.rst = rst; r.disp = disp; r.cmt = cmt; r.fv = fv; r.dead = dead;
        r.exc = exc; r.cause = cause; r.pc = pc; r.tv = tv; r.rdy = rdy;
        r.e_stall = es; r.e_flush = ef; r.e_trap = et; r.e_cause = ec;
        r.e_rv = erv; r.e_raddr = era; r.e_occ = eo;
        return r;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive at negedge, compare 1ns later, i.e. well clear of the posedge.
    task automatic run(vec_t v, string tag, bit do_chk);
        @(negedge clk);
        rst_n            = v.rst;
        disp_valid       = v.disp;
        cmt_commit       = v.cmt;
        cmt_flush_valid  = v.fv;
        cmt_all_dead     = v.dead;
        cmt_except_valid = v.exc;
        cmt_except_type  = v.cause;
        cmt_upd_pc       = v.pc;
        trap_vec         = v.tv;
        redirect_ready   = v.rdy;
        #1;
        if (do_chk) begin
            chk({tag, ".stall"}, 64'(disp_stall),     64'(v.e_stall));
            chk({tag, ".flush"}, 64'(flush_valid),    64'(v.e_flush));
            chk({tag, ".trap"},  64'(trap_valid),     64'(v.e_trap));
            chk({tag, ".cause"}, 64'(trap_cause),     64'(v.e_cause));
            chk({tag, ".rv"},    64'(redirect_valid), 64'(v.e_rv));
            chk({tag, ".raddr"}, 64'(redirect_vaddr), 64'(v.e_raddr));
            chk({tag, ".occ"},   64'(occupancy),      64'(v.e_occ));
        end
    endtask

    localparam logic [VW-1:0] PC  = 39'h80001000;
    localparam logic [VW-1:0] PC2 = 39'h00004440;
    localparam logic [VW-1:0] TV  = 39'h100;

    vec_t tbl[$];
    vec_t idle;

    initial begin
        idle = mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);

        // Reset state, five allocations, branch flush with a dead flush-valid
        // commit during DRAIN, held redirect, then an exception flush.
        tbl.push_back(idle);
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,OW'(k)));
        tbl.push_back(mk(1,0,1,1,0,0,0,PC,0,0,          0,0,0,0,0,0,5));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,           1,1,0,0,0,0,4));
        tbl.push_back(mk(1,0,1,1,1,0,0,39'h2222,0,0,    1,0,0,0,0,0,4));
        tbl.push_back(mk(1,0,1,0,1,0,0,0,0,0,           1,0,0,0,0,0,3));
        tbl.push_back(mk(1,0,1,0,1,0,0,0,0,0,           1,0,0,0,0,0,2));
        tbl.push_back(mk(1,0,1,0,1,0,0,0,0,0,           1,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,           1,0,0,0,0,0,0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,       1,0,0,0,1,PC,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,1,           1,0,0,0,1,PC,0));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,0,0,           0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1,1,0,1,2,39'h5555,TV,0,   0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,           1,1,1,2,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,           1,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,1,           1,0,0,0,1,TV,0));
        tbl.push_back(idle);

        run(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0), "rst", 0);
        foreach (tbl[i]) run(tbl[i], $sformatf("tbl%0d", i), 1);

        // Fill to capacity; a commit while full frees a slot only next cycle.
        for (int k = 0; k < SZ; k++) run(mk(1,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0), "fill", 0);
        run(mk(1,1,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,16), "full", 1);
        run(mk(1,1,1,0,0,0,0,0,0,0, 1,0,0,0,0,0,16), "full_cmt", 1);
        run(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,15), "after_full", 1);
        for (int k = 0; k < SZ-1; k++) run(mk(1,0,1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0), "empty", 0);
        run(idle, "emptied", 1);

        // Dispatch held high across the whole recovery sequence.
        run(mk(1,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0), "b_pre", 0);
        run(mk(1,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1), "b_pre", 1);
        run(mk(1,1,1,1,0,0,0,PC2,0,0, 0,0,0,0,0,0,2),   "b_trig",  1);
        run(mk(1,1,1,0,1,0,0,0,0,0,   1,1,0,0,0,0,2),   "b_flush", 1);
        run(mk(1,1,1,0,1,0,0,0,0,0,   1,0,0,0,0,0,1),   "b_drain", 1);
        run(mk(1,1,0,0,0,0,0,0,0,0,   1,0,0,0,0,0,0),   "b_drain0",1);
        run(mk(1,1,0,0,0,0,0,0,0,0,   1,0,0,0,1,PC2,0), "b_redir", 1);
        run(mk(1,1,0,0,0,0,0,0,0,1,   1,0,0,0,1,PC2,0), "b_ready", 1);
        run(mk(1,1,0,0,0,0,0,0,0,0,   0,0,0,0,0,0,0),   "b_resume",1);
        run(mk(1,0,0,0,0,0,0,0,0,0,   0,0,0,0,0,0,1),   "b_alloc", 1);

        // Reset while draining with blocks still outstanding.
        for (int k = 0; k < 3; k++) run(mk(1,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0), "c_pre", 0);
        run(mk(1,0,1,1,0,0,0,PC,0,0, 0,0,0,0,0,0,4), "c_trig",  1);
        run(mk(1,0,0,0,0,0,0,0,0,0,  1,1,0,0,0,0,3), "c_flush", 1);
        run(mk(1,0,0,0,0,0,0,0,0,0,  1,0,0,0,0,0,3), "c_drain", 1);
        run(mk(0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0,0,0), "c_rst",   0);
        run(idle, "c_after", 1);
        run(mk(1,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0), "c_idle", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
